// File: rtl/alu_unit.sv
// alu_unit: registered signed integer ALU (add/sub/mul/div) with zero and error flags.
// Operands are sign-extended to 2*WIDTH before any arithmetic. The widened operands remove
// overflow from add and sub. They also make most-negative / -1 representable without a special case.
module alu_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [3:0]           op,
    input  logic                 nvalid_data,
    output logic [2*WIDTH-1:0]   out,
    output logic                 zero,
    output logic                 error
);

    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd2;
    localparam logic [3:0] OpMul = 4'd4;
    localparam logic [3:0] OpDiv = 4'd8;

    logic signed [W2-1:0] a_ext;
    logic signed [W2-1:0] b_ext;
    logic signed [W2-1:0] div_b;
    logic                 div_by_zero;

    logic [W2-1:0] out_d,   out_q;
    logic          zero_d,  zero_q;
    logic          error_d, error_q;

    assign a_ext       = {{WIDTH{in1[WIDTH-1]}}, in1};
    assign b_ext       = {{WIDTH{in2[WIDTH-1]}}, in2};
    assign div_by_zero = (in2 == '0);
    // Feed the divider a harmless divisor on zero so it never produces X.
    assign div_b       = div_by_zero ? W2'(1) : b_ext;

    // Next-state result and flags from the current opcode and operands.
    always_comb begin
        out_d   = '0;
        error_d = 1'b0;
        unique case (op)
            OpAdd: out_d = a_ext + b_ext;
            OpSub: out_d = a_ext - b_ext;
            // The product of two sign-extended WIDTH-bit values always fits in W2 bits.
            OpMul: out_d = a_ext * b_ext;
            OpDiv: begin
                if (div_by_zero) begin
                    error_d = 1'b1;
                end else begin
                    out_d = a_ext / div_b;
                end
            end
            default: error_d = 1'b1;
        endcase
        zero_d = (out_d == '0) && !error_d;
    end

    // Output registers: reset clears, invalid data holds, otherwise capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            zero_q  <= 1'b0;
            error_q <= 1'b0;
        end else if (!nvalid_data) begin
            out_q   <= out_d;
            zero_q  <= zero_d;
            error_q <= error_d;
        end
    end

    assign out   = out_q;
    assign zero  = zero_q;
    assign error = error_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: scoreboard bench for alu_unit. It uses an integer reference model and a queue of expected results.
module tb_alu_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned W2    = 2 * WIDTH;

    typedef struct {
        logic [W2-1:0] out;
        logic          zero;
        logic          error;
        string         tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       op;
    logic             nvalid_data;
    logic [W2-1:0]    out;
    logic             zero;
    logic             error;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];

    // Reference model state, mirroring the registered outputs.
    logic [W2-1:0] m_out;
    logic          m_zero;
    logic          m_err;

    alu_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in1         (in1),
        .in2         (in2),
        .op          (op),
        .nvalid_data (nvalid_data),
        .out         (out),
        .zero        (zero),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Integer reference: wrap operands to WIDTH bits and interpret them as signed.
    task automatic model(input logic r, input int a, input int b, input logic [3:0] o,
                         input logic nv);
        logic signed [WIDTH-1:0] ta;
        logic signed [WIDTH-1:0] tb;
        int sa;
        int sb;
        int res;
        logic e;
        ta = a[WIDTH-1:0];
        tb = b[WIDTH-1:0];
        sa = ta;
        sb = tb;
        res = 0;
        e = 1'b0;
        if (r) begin
            m_out = '0; m_zero = 1'b0; m_err = 1'b0;
        end else if (!nv) begin
            case (o)
                4'd0: res = sa + sb;
                4'd2: res = sa - sb;
                4'd4: res = sa * sb;
                4'd8: if (sb == 0) e = 1'b1; else res = sa / sb;
                default: e = 1'b1;
            endcase
            m_out  = res[W2-1:0];
            m_err  = e;
            m_zero = (res == 0) && !e;
        end
    endtask

    // Drive one cycle of stimulus, push the expectation, then pop and compare after the edge.
    task automatic step(input string tag, input logic r, input int a, input int b,
                        input logic [3:0] o, input logic nv);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = r;
        in1 = a[WIDTH-1:0];
        in2 = b[WIDTH-1:0];
        op = o;
        nvalid_data = nv;
        model(r, a, b, o, nv);
        e.out = m_out; e.zero = m_zero; e.error = m_err; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({got.tag, ".out"},   32'(out),   32'(got.out));
        check({got.tag, ".zero"},  32'(zero),  32'(got.zero));
        check({got.tag, ".error"}, 32'(error), 32'(got.error));
    endtask

    initial begin
        rst = 1'b1; in1 = '0; in2 = '0; op = '0; nvalid_data = 1'b0;
        m_out = '0; m_zero = 1'b0; m_err = 1'b0;

        step("rst0", 1'b1, 77, -3, 4'd4, 1'b0);
        step("rst1", 1'b1, -9, 0, 4'd8, 1'b1);
        check("rst_out_const", 32'(out), 32'h0);
        step("add", 1'b0, 3, 5, 4'd0, 1'b0);
        check("add_out_const", 32'(out), 32'd8);
        step("sub", 1'b0, 3, 5, 4'd2, 1'b0);
        check("sub_out_const", 32'(out), 32'h0000_FFFE);
        step("mul", 1'b0, 3, 5, 4'd4, 1'b0);
        check("mul_out_const", 32'(out), 32'd15);
        step("div0q", 1'b0, 3, 5, 4'd8, 1'b0);
        check("divq_zero_const", 32'(zero), 32'd1);
        step("div_exact", 1'b0, 8, 2, 4'd8, 1'b0);
        check("div_exact_const", 32'(out), 32'd4);
        step("div_by_zero", 1'b0, 8, 0, 4'd8, 1'b0);
        check("dbz_err_const", 32'(error), 32'd1);
        step("div_recover", 1'b0, 8, 2, 4'd8, 1'b0);
        step("mul_neg", 1'b0, 2, -2, 4'd4, 1'b0);
        check("mul_neg_const", 32'(out), 32'h0000_FFFC);
        step("mul_wrap", 1'b0, 129, -129, 4'd4, 1'b0);
        check("mul_wrap_const", 32'(out), 32'h0000_C0FF);
        step("mul_min", 1'b0, -128, -128, 4'd4, 1'b0);
        check("mul_min_const", 32'(out), 32'd16384);
        step("div_min", 1'b0, -128, -1, 4'd8, 1'b0);
        check("div_min_const", 32'(out), 32'd128);
        step("ill1", 1'b0, 3, 5, 4'd1, 1'b0);
        step("ill3", 1'b0, 3, 5, 4'd3, 1'b0);
        step("ill15", 1'b0, 3, 5, 4'd15, 1'b0);
        check("ill_err_const", 32'(error), 32'd1);
        step("hold_base", 1'b0, 3, 5, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 7, 5, 4'd4, 1'b1);
        check("hold_out_const", 32'(out), 32'd8);
        step("hold_release", 1'b0, 7, 5, 4'd4, 1'b0);
        check("release_const", 32'(out), 32'd35);
        step("mid_rst", 1'b1, 7, 5, 4'd4, 1'b1);
        step("post_rst", 1'b0, -7, 3, 4'd2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] ops [5];
            int ra;
            int rb;
            int k;
            ops[0] = 4'd0; ops[1] = 4'd2; ops[2] = 4'd4; ops[3] = 4'd8; ops[4] = 4'd6;
            ra = int'($urandom_range(0, 255)) - 128;
            rb = int'($urandom_range(0, 255)) - 128;
            if ((i % 7) == 0) rb = 0;
            k = int'($urandom_range(0, 4));
            step("rand", 1'b0, ra, rb, ops[k], ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
